// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-iteration MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Ports:
//   clk, rst (async, active high)
//   start, op[1:0] (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), a, b: operands sampled when IDLE
//   hi_we, lo_we, wd: MTHI/MTLO writes, honoured only when IDLE and start is low
//   hi, lo: result registers; busy: operation in flight; done: one-cycle result pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] op_r;
  logic neg_q, neg_r;
  logic [W-1:0] ma, mb, a_raw, rem;
  logic [2*W-1:0] p;
  logic [W-1:0] abs_a, abs_b;
  logic [W:0] msum, sh;
  logic ge;
  logic [W-1:0] diff, quo_fix, rem_fix;
  logic [2*W-1:0] prod_fix;
  // Signed ops work on magnitudes; sign is restored in FIX.
  assign abs_a = (op[0] && a[W-1]) ? -a : a;
  assign abs_b = (op[0] && b[W-1]) ? -b : b;
  // Multiply: p = {partial product, remaining multiplier bits}, shifted right each step.
  assign msum = {1'b0, p[2*W-1:W]} + ({(W+1){p[0]}} & {1'b0, ma});
  // Divide: p[W-1:0] shifts dividend bits out at the top and quotient bits in at the bottom.
  assign sh = {rem, p[W-1]};
  assign ge = sh >= {1'b0, mb};
  assign diff = sh[W-1:0] - mb;
  assign prod_fix = neg_q ? -p : p;
  assign quo_fix = neg_q ? -p[W-1:0] : p[W-1:0];
  assign rem_fix = neg_r ? -rem : rem;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ma <= '0;
      mb <= '0;
      a_raw <= '0;
      rem <= '0;
      p <= '0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy <= 1'b1;
            op_r <= op;
            ma <= abs_a;
            mb <= abs_b;
            a_raw <= a;
            neg_q <= op[0] & (a[W-1] ^ b[W-1]);
            neg_r <= op[0] & op[1] & a[W-1];
            cnt <= '0;
            rem <= '0;
            p <= {{W{1'b0}}, op[1] ? abs_a : abs_b};
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        RUN: begin
          if (op_r[1]) begin
            rem <= ge ? diff : sh[W-1:0];
            p[W-1:0] <= {p[W-2:0], ge};
          end else begin
            p <= {msum, p[W-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          if (op_r[1]) begin
            // Divide by zero reports the raw dividend and an all-ones quotient.
            hi <= (mb == '0) ? a_raw : rem_fix;
            lo <= (mb == '0) ? '1 : quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
